sw_reg_read: RTL and testbench

- Read-only software register on a Wishbone slave port.
- Fabric logic continuously drives a data word. The processor reads the word over Wishbone within an address window.
- Sits between the processor bus interconnect and user fabric logic. It gives software visibility of fabric status values.
- All logic runs in a single clock domain.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_slave_resp.sv | 34 +++
 rtl/sw_reg_read.sv | 66 ++++++
 tb/tb_sw_reg_read.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone bus widths, response encoding and the address-window decode helper.
package wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_ACK  = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    // Inclusive unsigned window test; every address inside aliases the same register.
    function automatic logic in_range(
        input logic [WB_ADDR_W-1:0] adr,
        input logic [WB_ADDR_W-1:0] base,
        input logic [WB_ADDR_W-1:0] high
    );
        return (adr >= base) && (adr <= high);
    endfunction

endpackage

// File: rtl/wb_slave_resp.sv
// Single-cycle Wishbone response generator: a request produces one ack (read) or one err (write).
module wb_slave_resp
    import wb_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic req_i,
    input  logic we_i,
    output logic ack_o,
    output logic err_o
);

    resp_e resp_q;
    resp_e resp_d;

    always_comb begin
        resp_d = RESP_NONE;
        if (req_i) begin
            resp_d = we_i ? RESP_ERR : RESP_ACK;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resp_q <= RESP_NONE;
        end else begin
            resp_q <= resp_d;
        end
    end

    assign ack_o = (resp_q == RESP_ACK);
    assign err_o = (resp_q == RESP_ERR);

endmodule

// File: rtl/sw_reg_read.sv
// Read-only software register: fabric value sampled every cycle, exposed to the CPU over Wishbone.
module sw_reg_read
    import wb_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_FFFF,
    parameter int          C_DATA_WIDTH = 32
)(
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [3:0]              wb_sel_i,
    input  logic [WB_ADDR_W-1:0]    wb_adr_i,
    input  logic [WB_DATA_W-1:0]    wb_dat_i,
    output logic [WB_DATA_W-1:0]    wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    input  logic                    fabric_clk,
    input  logic [C_DATA_WIDTH-1:0] fabric_data_in
);

    logic [C_DATA_WIDTH-1:0] shadow_q;
    logic [WB_DATA_W-1:0]    dat_q;
    logic [WB_DATA_W-1:0]    dat_d;
    logic [WB_DATA_W-1:0]    shadowExt;
    logic                    hit;
    logic                    req;
    logic                    unusedInputs;

    // Byte selects, write data and the fabric clock have no function in a read-only register.
    assign unusedInputs = ^{wb_sel_i, wb_dat_i, fabric_clk};

    // Gating on the current ack/err keeps every response a one-cycle pulse.
    assign hit = in_range(wb_adr_i, C_BASEADDR, C_HIGHADDR);
    assign req = wb_cyc_i & wb_stb_i & hit & ~wb_ack_o & ~wb_err_o;

    always_comb begin
        shadowExt                      = '0;
        shadowExt[C_DATA_WIDTH-1:0]    = shadow_q;
        dat_d                          = (req & ~wb_we_i) ? shadowExt : '0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            shadow_q <= '0;
            dat_q    <= '0;
        end else begin
            shadow_q <= fabric_data_in;
            dat_q    <= dat_d;
        end
    end

    assign wb_dat_o = dat_q;

    wb_slave_resp u_resp (
        .clk_i   (wb_clk_i),
        .reset_i (wb_rst_i),
        .req_i   (req),
        .we_i    (wb_we_i),
        .ack_o   (wb_ack_o),
        .err_o   (wb_err_o)
    );

endmodule

// File: tb/tb_sw_reg_read.sv
// Directed bench for sw_reg_read: a 32-bit instance and a 1-bit instance share one Wishbone master.
module tb_sw_reg_read;

    typedef struct {
        string       tag;
        int          dut;
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] datIn;
    logic [31:0] fab0;
    logic [0:0]  fab1;
    logic [31:0] dat0;
    logic [31:0] dat1;
    logic        ack0;
    logic        ack1;
    logic        err0;
    logic        err1;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sw_reg_read u_dut0 (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wb_cyc_i       (cyc),
        .wb_stb_i       (stb),
        .wb_we_i        (we),
        .wb_sel_i       (sel),
        .wb_adr_i       (adr),
        .wb_dat_i       (datIn),
        .wb_dat_o       (dat0),
        .wb_ack_o       (ack0),
        .wb_err_o       (err0),
        .fabric_clk     (clk),
        .fabric_data_in (fab0)
    );

    sw_reg_read #(.C_DATA_WIDTH(1)) u_dut1 (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wb_cyc_i       (cyc),
        .wb_stb_i       (stb),
        .wb_we_i        (we),
        .wb_sel_i       (sel),
        .wb_adr_i       (adr),
        .wb_dat_i       (datIn),
        .wb_dat_o       (dat1),
        .wb_ack_o       (ack1),
        .wb_err_o       (err1),
        .fabric_clk     (clk),
        .fabric_data_in (fab1)
    );

    task automatic applyStimulus(input logic r, input logic c, input logic s,
                                 input logic w, input logic [31:0] a);
        rst = r;
        cyc = c;
        stb = s;
        we  = w;
        adr = a;
    endtask

    task automatic pushExp(input string tag, input int dut, input logic a,
                           input logic e, input logic [31:0] d);
        exp_t x;
        x.tag = tag;
        x.dut = dut;
        x.ack = a;
        x.err = e;
        x.dat = d;
        sb.push_back(x);
    endtask

    // Advances one edge and retires every expectation queued for it.
    task automatic checkOutput();
        exp_t        e;
        logic        a;
        logic        r;
        logic [31:0] d;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = (e.dut == 0) ? ack0 : ack1;
            r = (e.dut == 0) ? err0 : err1;
            d = (e.dut == 0) ? dat0 : dat1;
            total++;
            assert (a === e.ack) else begin
                bad++;
                $error("[TB] FAIL %s ack observed=%0b expected=%0b", e.tag, a, e.ack);
            end
            total++;
            assert (r === e.err) else begin
                bad++;
                $error("[TB] FAIL %s err observed=%0b expected=%0b", e.tag, r, e.err);
            end
            total++;
            assert (d === e.dat) else begin
                bad++;
                $error("[TB] FAIL %s dat observed=%h expected=%h", e.tag, d, e.dat);
            end
        end
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        pushExp(tag, 0, 1'b0, 1'b0, 32'h0);
        checkOutput();
    endtask

    initial begin
        logic [31:0] prevFab;
        logic        expAck;

        sel   = 4'hF;
        datIn = 32'h0;
        fab0  = 32'hA5A5_1234;
        fab1  = 1'b0;

        $display("[TB] reset with a live read request");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            pushExp($sformatf("reset%0d", i), 0, 1'b0, 1'b0, 32'h0);
            pushExp($sformatf("reset%0d_w1", i), 1, 1'b0, 1'b0, 32'h0);
            checkOutput();
        end
        idleCycle("post_reset_idle");

        $display("[TB] basic read");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        pushExp("read_ack", 0, 1'b1, 1'b0, 32'hA5A5_1234);
        checkOutput();
        idleCycle("read_release");

        $display("[TB] write rejection");
        datIn = 32'hEEEE_EEEE;
        sel   = 4'hE;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
        pushExp("write_err", 0, 1'b0, 1'b1, 32'h0);
        checkOutput();
        idleCycle("write_release");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        pushExp("read_after_write", 0, 1'b1, 1'b0, 32'hA5A5_1234);
        checkOutput();
        idleCycle("raw_release");

        $display("[TB] address window and strobe qualification");
        fab0 = 32'h1357_9BDF;
        idleCycle("window_prep");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_FFFC);
        pushExp("window_top", 0, 1'b1, 1'b0, 32'h1357_9BDF);
        checkOutput();
        idleCycle("window_top_release");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0001_0000);
        for (int i = 0; i < 10; i++) begin
            pushExp($sformatf("window_miss%0d", i), 0, 1'b0, 1'b0, 32'h0);
            checkOutput();
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        pushExp("window_miss_write", 0, 1'b0, 1'b0, 32'h0);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        pushExp("cyc_low", 0, 1'b0, 1'b0, 32'h0);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        pushExp("stb_low", 0, 1'b0, 1'b0, 32'h0);
        checkOutput();

        $display("[TB] held strobe with incrementing fabric");
        fab0 = 32'h0;
        idleCycle("held_prep");
        prevFab = 32'h0;
        expAck  = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100);
        for (int i = 1; i <= 6; i++) begin
            fab0 = i;
            pushExp($sformatf("held%0d", i), 0, expAck, 1'b0, expAck ? prevFab : 32'h0);
            checkOutput();
            prevFab = i;
            expAck  = ~expAck;
        end
        idleCycle("held_release");

        $display("[TB] one-bit instance sample latency");
        fab1 = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        pushExp("w1_edgeK", 1, 1'b1, 1'b0, 32'h0);
        checkOutput();
        pushExp("w1_edgeK1", 1, 1'b0, 1'b0, 32'h0);
        checkOutput();
        pushExp("w1_edgeK2", 1, 1'b1, 1'b0, 32'h0000_0001);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        pushExp("w1_release", 1, 1'b0, 1'b0, 32'h0);
        checkOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
